vm_seq_mult: RTL and testbench

- Registered signed (two's-complement) WIDTH x WIDTH multiplier producing a 2*WIDTH-bit product.
- Operands are sampled on every rising clock edge. The product of those operands appears on `result` after the same edge, so latency is one clock.
- Fully pipelined with a throughput of one multiply per cycle.
- Used as the sequential integer multiply unit in the multiplier datapath.

---
 rtl/vm_seq_mult.sv | 137 +++++++++++++
 tb/tb_vm_seq_mult.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/vm_seq_mult.sv
// Registered signed WIDTH x WIDTH multiplier: radix-4 Booth partial products,
// carry-save reduction tree and final carry-propagate adder, one-cycle latency.
module vm_seq_mult #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   result
);

    localparam int P    = 2 * WIDTH;
    localparam int NPP  = WIDTH / 2;
    // One extra operand carries the +1 of every negated partial product.
    localparam int NOPS = NPP + 1;

    typedef struct packed {
        logic one;
        logic two;
        logic neg;
    } booth_t;

    function automatic int csa_levels(input int n_ops);
        int n;
        int lvl;
        n   = n_ops;
        lvl = 0;
        while (n > 2) begin
            n   = (n / 3) * 2 + (n % 3);
            lvl = lvl + 1;
        end
        return lvl;
    endfunction

    localparam int LEVELS = csa_levels(NOPS);

    function automatic booth_t booth_encode(input logic [2:0] trip);
        booth_t d;
        d = '0;
        case (trip)
            3'b001, 3'b010: d.one = 1'b1;
            3'b011:         d.two = 1'b1;
            3'b100: begin
                d.two = 1'b1;
                d.neg = 1'b1;
            end
            3'b101, 3'b110: begin
                d.one = 1'b1;
                d.neg = 1'b1;
            end
            default:        d = '0;
        endcase
        return d;
    endfunction

    logic [WIDTH:0] w_b_ext;
    logic [P-1:0]   w_a_ext;
    booth_t         w_digit [NPP];
    logic [P-1:0]   w_ops   [NOPS];
    logic [P-1:0]   w_sum_s;
    logic [P-1:0]   w_sum_c;
    logic [P-1:0]   w_product;

    // Implicit zero below B[0]; the top digit sees B[WIDTH-1] as its sign bit.
    assign w_b_ext = {B, 1'b0};
    assign w_a_ext = {{WIDTH{A[WIDTH-1]}}, A};

    // NOTE: every combinational output gets a default before any conditional
    // assignment, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin : booth_pp
        logic [P-1:0] mag;
        logic [P-1:0] corr;
        corr = '0;
        mag  = '0;
        for (int i = 0; i < NPP; i++) begin
            w_digit[i] = booth_encode(w_b_ext[2*i+2 -: 3]);
            if (w_digit[i].one)
                mag = w_a_ext;
            else if (w_digit[i].two)
                mag = w_a_ext << 1;
            else
                mag = '0;
            // Negation as one's complement here plus a +1 in the correction row.
            w_ops[i]  = (mag ^ {P{w_digit[i].neg}}) << (2 * i);
            corr[2*i] = w_digit[i].neg;
        end
        w_ops[NPP] = corr;
    end

    // Wallace-style reduction: each level folds groups of three rows into a
    // sum row and a shifted carry row until only two rows remain.
    always_comb begin : csa_tree
        logic [P-1:0] cur [NOPS];
        logic [P-1:0] nxt [NOPS];
        int n;
        int m;
        cur = w_ops;
        n   = NOPS;
        for (int lvl = 0; lvl < LEVELS; lvl++) begin
            for (int k = 0; k < NOPS; k++)
                nxt[k] = '0;
            m = 0;
            for (int g = 0; g < NOPS / 3; g++) begin
                if (3 * g + 2 < n) begin
                    nxt[m]   = cur[3*g] ^ cur[3*g+1] ^ cur[3*g+2];
                    nxt[m+1] = ((cur[3*g] & cur[3*g+1]) |
                                (cur[3*g] & cur[3*g+2]) |
                                (cur[3*g+1] & cur[3*g+2])) << 1;
                    m = m + 2;
                end
            end
            for (int k = 0; k < NOPS; k++) begin
                if (k >= 3 * (n / 3) && k < n) begin
                    nxt[m] = cur[k];
                    m = m + 1;
                end
            end
            cur = nxt;
            n   = m;
        end
        w_sum_s = cur[0];
        w_sum_c = cur[1];
    end

    assign w_product = w_sum_s + w_sum_c;

    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            result <= '0;
        else
            result <= w_product;
    end

endmodule

// File: tb/tb_vm_seq_mult.sv
// Self-checking bench for vm_seq_mult: directed corners from the datasheet,
// then 10k random back-to-back multiplies with async reset pulses.
module tb_vm_seq_mult;

    localparam int W = 32;

    logic           clk;
    logic           reset;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic [2*W-1:0] result;

    int n_checks;
    int n_errors;

    vm_seq_mult #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .A      (A),
        .B      (B),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2*W-1:0] got,
                         input logic [2*W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: plain signed 64-bit arithmetic on the sign-extended operands.
    function automatic logic [2*W-1:0] model(input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        longint p;
        p = longint'(signed'(a)) * longint'(signed'(b));
        return p;
    endfunction

    task automatic directed(input string tag, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [2*W-1:0] exp);
        @(negedge clk);
        A = a;
        B = b;
        @(posedge clk);
        #1;
        check(tag, result, exp);
    endtask

    task automatic apply_rand(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        A = a;
        B = b;
        @(posedge clk);
        #1;
        check("rand", result, model(a, b));
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 9))
            0:       return '0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 1000)) - 32'd500;
            default: return $urandom();
        endcase
    endfunction

    task automatic reset_pulse(input int edges);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("rst_async", result, '0);
        repeat (edges) begin
            @(posedge clk);
            #1;
            check("rst_hold", result, '0);
        end
        @(negedge clk);
        reset = 1'b1;
        A = pick_operand();
        B = pick_operand();
        @(posedge clk);
        #1;
        check("rst_release", result, model(A, B));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        A = 32'd5;
        B = 32'd7;
        #1;
        check("reset_state", result, '0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("reset_edges", result, '0);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("first_load", result, 64'd35);

        directed("mix_50_m40",   32'd50,   -32'sd40,   -64'sd2000);
        directed("mix_m10_325",  -32'sd10, 32'd325,    -64'sd3250);
        directed("mix_m500_2k",  -32'sd500, 32'd2000,  -64'sd1000000);
        directed("mix_m999_999", -32'sd999, 32'd999,   -64'sd998001);
        directed("same_pos",     32'd90,   32'd70,     64'd6300);
        directed("same_neg",     -32'sd80, -32'sd65,   64'd5200);
        directed("mul_zero",     32'd98756, 32'd0,     64'd0);
        directed("mul_one",      32'd98765, 32'd1,     64'd98765);
        directed("neg1_neg1",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1);
        directed("max_neg1",     32'h7FFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0001);
        directed("min_min",      32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        directed("min_max",      32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000);
        directed("max_max",      32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);
        directed("neg_one_sext", 32'hFFFF_FF00, 32'd1,   64'hFFFF_FFFF_FFFF_FF00);

        // Inputs changing between edges must not reach the output.
        @(negedge clk);
        A = 32'd123;
        B = 32'd456;
        #1;
        check("hold", result, 64'hFFFF_FFFF_FFFF_FF00);

        for (int i = 0; i < 10000; i++) begin
            if (i == 2500 || i == 5000 || i == 7500)
                reset_pulse(i / 2500);
            apply_rand(pick_operand(), pick_operand());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
